// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a registered-read instruction memory and
// presents fetched words to decode. It handles stall, redirect and sync reset.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        misalign
);

   localparam int unsigned XLEN = 32;

   // FLOW means the word arriving on imem_rdata this cycle is a real fetch
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FLOW  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   w_pc_next;
   logic [XLEN-1:0]   r_f_pc;
   logic [XLEN-1:0]   w_f_pc_next;
   logic              r_id_valid;
   logic              w_id_valid_next;
   logic [XLEN-1:0]   r_id_instr;
   logic [XLEN-1:0]   w_id_instr_next;
   logic [XLEN-1:0]   r_id_pc;
   logic [XLEN-1:0]   w_id_pc_next;
   logic              r_misalign;
   logic              w_misalign_next;
   logic [XLEN-1:0]   w_imem_addr;

   // Next-state and memory address; redirect outranks stall
   always_comb begin
      w_state_next    = r_state;
      w_pc_next       = r_pc;
      w_f_pc_next     = r_f_pc;
      w_id_valid_next = r_id_valid;
      w_id_instr_next = r_id_instr;
      w_id_pc_next    = r_id_pc;
      w_misalign_next = redirect & (|redirect_pc[1:0]);
      w_imem_addr     = {2'b00, r_pc[XLEN-1:2]};

      if (redirect) begin
         w_pc_next       = {redirect_pc[XLEN-1:2], 2'b00};
         w_state_next    = ST_EMPTY;
         w_id_valid_next = 1'b0;
      end else if (stall) begin
         // Re-read the in-flight word so imem_rdata still matches f_pc
         if (reset) begin
            w_imem_addr = {2'b00, r_f_pc[XLEN-1:2]};
         end
      end else begin
         w_pc_next       = r_pc + XLEN'(4);
         w_f_pc_next     = r_pc;
         w_state_next    = ST_FLOW;
         w_id_instr_next = imem_rdata;
         w_id_pc_next    = r_f_pc;
         w_id_valid_next = (r_state == ST_FLOW);
      end
   end

   // State register with synchronous active-low reset overriding everything
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_EMPTY;
         r_pc       <= RESET_PC;
         r_f_pc     <= '0;
         r_id_valid <= 1'b0;
         r_id_instr <= '0;
         r_id_pc    <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_f_pc     <= w_f_pc_next;
         r_id_valid <= w_id_valid_next;
         r_id_instr <= w_id_instr_next;
         r_id_pc    <= w_id_pc_next;
         r_misalign <= w_misalign_next;
      end
   end

   assign imem_addr = w_imem_addr;
   assign id_valid  = r_id_valid;
   assign id_instr  = r_id_instr;
   assign id_pc     = r_id_pc;
   assign misalign  = r_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory model returns 32'h100 + word index
// one cycle after the address is presented.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        misalign;

   int unsigned n_checks;
   int unsigned n_fails;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .misalign    (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read instruction memory
   always @(posedge clk) imem_rdata <= 32'h100 + imem_addr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_id(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr);
      check_eq({tag, ".valid"}, 32'(id_valid), 32'(v));
      check_eq({tag, ".pc"}, id_pc, pc);
      check_eq({tag, ".instr"}, id_instr, instr);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks    = 0;
      n_fails     = 0;
      reset       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_rdata  = 32'h0;

      // Reset with a misaligned redirect and stall pending: reset must win
      @(negedge clk);
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h22;
      tick();
      tick();
      check_id("rst", 1'b0, 32'h0, 32'h0);
      check_eq("rst.misalign", 32'(misalign), 32'h0);
      check_eq("rst.imem_addr", imem_addr, 32'h0);

      // Release: first instruction two edges later, then sequential flow
      reset    = 1'b1;
      stall    = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      tick();
      check_eq("rel1.valid", 32'(id_valid), 32'h0);
      check_eq("rel1.imem_addr", imem_addr, 32'h1);
      tick();
      check_id("rel2", 1'b1, 32'h0, 32'h100);
      tick();
      check_id("rel3", 1'b1, 32'h4, 32'h101);
      tick();
      check_id("rel4", 1'b1, 32'h8, 32'h102);

      // Three stalled cycles hold decode; memory re-reads the in-flight word
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_id("stall", 1'b1, 32'h8, 32'h102);
         check_eq("stall.imem_addr", imem_addr, 32'h3);
      end
      stall = 1'b0;
      tick();
      check_id("unstall1", 1'b1, 32'hC, 32'h103);
      tick();
      check_id("unstall2", 1'b1, 32'h10, 32'h104);

      // Aligned redirect flushes, target appears two edges later
      redirect    = 1'b1;
      redirect_pc = 32'h20;
      tick();
      check_id("redir0", 1'b0, 32'h10, 32'h104);
      check_eq("redir0.misalign", 32'(misalign), 32'h0);
      redirect = 1'b0;
      tick();
      check_eq("redir1.valid", 32'(id_valid), 32'h0);
      tick();
      check_id("redir2", 1'b1, 32'h20, 32'h108);
      tick();
      check_id("redir3", 1'b1, 32'h24, 32'h109);

      // Redirect together with stall, misaligned target
      redirect    = 1'b1;
      stall       = 1'b1;
      redirect_pc = 32'h22;
      tick();
      check_eq("mis0.valid", 32'(id_valid), 32'h0);
      check_eq("mis0.misalign", 32'(misalign), 32'h1);
      redirect = 1'b0;
      stall    = 1'b0;
      tick();
      check_eq("mis1.misalign", 32'(misalign), 32'h0);
      check_eq("mis1.valid", 32'(id_valid), 32'h0);
      tick();
      check_id("mis2", 1'b1, 32'h20, 32'h108);

      // Back-to-back redirects: only the last target is fetched
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect_pc = 32'h80;
      tick();
      redirect = 1'b0;
      tick();
      check_eq("dbl1.valid", 32'(id_valid), 32'h0);
      tick();
      check_id("dbl2", 1'b1, 32'h80, 32'h120);

      // PC wrap from the top of the address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      check_eq("wrap0.misalign", 32'(misalign), 32'h0);
      redirect = 1'b0;
      tick();
      tick();
      check_id("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h4000_00FF);
      tick();
      check_id("wrap2", 1'b1, 32'h0, 32'h100);
      check_eq("wrap2.misalign", 32'(misalign), 32'h0);

      // Mid-flow reset during stall discards everything, fetch restarts
      stall = 1'b1;
      reset = 1'b0;
      tick();
      check_id("mrst", 1'b0, 32'h0, 32'h0);
      check_eq("mrst.imem_addr", imem_addr, 32'h0);
      reset = 1'b1;
      stall = 1'b0;
      tick();
      check_eq("mrst1.valid", 32'(id_valid), 32'h0);
      tick();
      check_id("mrst2", 1'b1, 32'h0, 32'h100);
      tick();
      check_id("mrst3", 1'b1, 32'h4, 32'h101);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
